// File: rtl/hermitian_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Package   : hermitian_pkg                                                |
// | Purpose   : Shared types and helpers for the Hermitian frame mapper:     |
// |             complex sample struct, FSM state enum and the conjugating    |
// |             negation used for the mirrored half of the frame.            |
// | Macro     : HERM_NEG_SAT_EN - saturate -(-2^(W-1)) to +2^(W-1)-1         |
// | Revision  : 1.0  initial release                                         |
// +--------------------------------------------------------------------------+
package hermitian_pkg;

  // Component width of the datapath; the mapper's W parameter must match.
  localparam int CPLX_W = 24;

  typedef struct packed {
    logic signed [CPLX_W-1:0] re;
    logic signed [CPLX_W-1:0] im;
  } cplx_t;

  typedef enum logic [0:0] {
    LOAD = 1'b0,
    EMIT = 1'b1
  } state_t;

  localparam logic signed [CPLX_W-1:0] c_cplx_min = {1'b1, {(CPLX_W-1){1'b0}}};

  // True when negating the imaginary part cannot be represented.
  function automatic logic neg_overflows(input cplx_t x);
    return (x.im == c_cplx_min);
  endfunction

  // Complex conjugate: real part passes, imaginary part negated.
  function automatic cplx_t conj_neg(input cplx_t x);
    cplx_t r;
    r.re = x.re;
`ifdef HERM_NEG_SAT_EN
    if (neg_overflows(x)) begin
      r.im = ~c_cplx_min;
    end else begin
      r.im = -x.im;
    end
`else
    r.im = -x.im;
`endif
    return r;
  endfunction

endpackage
`default_nettype wire

// File: rtl/hermitian_sym_buf.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module    : hermitian_sym_buf                                            |
// | Purpose   : DEPTH-entry complex register file holding one frame of data  |
// |             symbols. One synchronous write port, one asynchronous read.  |
// | Ports     : clk            clock                                         |
// |             we/waddr/wdata write port                                    |
// |             raddr/rdata    combinational read port                       |
// | Revision  : 1.0  initial release                                         |
// +--------------------------------------------------------------------------+
module hermitian_sym_buf
  import hermitian_pkg::*;
#(
  parameter int DEPTH = 7,
  parameter int ABW   = 3
) (
  input  logic           clk,
  input  logic           we,
  input  logic [ABW-1:0] waddr,
  input  cplx_t          wdata,
  input  logic [ABW-1:0] raddr,
  output cplx_t          rdata
);

  // Storage has no reset: entries are always rewritten before being read.
  cplx_t r_mem [0:DEPTH-1];

  always_ff @(posedge clk) begin
    if (we) begin
      r_mem[waddr] <= wdata;
    end
  end

  assign rdata = r_mem[raddr];

endmodule
`default_nettype wire

// File: rtl/hermitian_frame_mapper.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module    : hermitian_frame_mapper                                       |
// | Purpose   : Collects M = N/2-1 complex symbols, then streams an N-bin    |
// |             Hermitian-symmetric IFFT frame:                              |
// |             X[0]=0, X[k]=d[k-1], X[N/2]=0, X[N-k]=conj(X[k]).            |
// | Ports     : clk, reset (async, active-low)                               |
// |             in_valid/in_ready/in_real/in_imag     symbol input stream    |
// |             out_valid/out_ready/out_real/out_imag bin output stream      |
// |             out_sof/out_eof  first/last bin marker, out_idx bin index    |
// |             sat_flag         (HERM_NEG_SAT_EN only) negation saturated   |
// | Macro     : HERM_NEG_SAT_EN - saturating negation + sat_flag output      |
// | Revision  : 1.0  initial release                                         |
// +--------------------------------------------------------------------------+
module hermitian_frame_mapper
  import hermitian_pkg::*;
#(
  parameter  int W  = CPLX_W,
  parameter  int N  = 16,
  localparam int AW = $clog2(N)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [W-1:0]  in_real,
  input  logic [W-1:0]  in_imag,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [W-1:0]  out_real,
  output logic [W-1:0]  out_imag,
  output logic          out_sof,
  output logic          out_eof,
  output logic [AW-1:0] out_idx
`ifdef HERM_NEG_SAT_EN
  ,
  output logic          sat_flag
`endif
);

  localparam int M  = N/2 - 1;
  localparam int BW = AW - 1;   // buffer address width; M < 2^BW

  localparam logic [AW-1:0] c_half  = AW'(N/2);
  localparam logic [AW-1:0] c_last  = AW'(N-1);
  localparam logic [BW-1:0] c_wlast = BW'(M-1);

  state_t        r_state;
  state_t        w_state_nxt;
  logic [BW-1:0] r_wptr;
  logic [AW-1:0] r_k;          // index of the next bin to load into the output register

  logic          w_in_fire;
  logic          w_last_in;
  logic          w_out_fire;
  logic          w_eof_fire;
  logic          w_out_load;
  logic          w_zero_bin;
  logic          w_mirror;
  logic [BW-1:0] w_raddr;
  cplx_t         w_wdata;
  cplx_t         w_rdata;
  cplx_t         w_bin;
`ifdef HERM_NEG_SAT_EN
  logic          w_sat;
`endif

  // ---------------------------------------------------------------- handshakes
  assign in_ready   = (r_state == LOAD);
  assign w_in_fire  = in_valid && in_ready;
  assign w_last_in  = w_in_fire && (r_wptr == c_wlast);
  assign w_out_fire = out_valid && out_ready;
  assign w_eof_fire = w_out_fire && out_eof;

  // Bin 0 is constant zero, so it can be loaded on the same edge that
  // captures the last symbol. Afterwards the register refills whenever the
  // current bin leaves, until the eof bin is taken.
  assign w_out_load = w_last_in ||
                      ((r_state == EMIT) && !w_eof_fire && (!out_valid || out_ready));

  // ---------------------------------------------------------------- FSM
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= LOAD;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      LOAD:    if (w_last_in)  w_state_nxt = EMIT;
      EMIT:    if (w_eof_fire) w_state_nxt = LOAD;
      default: w_state_nxt = LOAD;
    endcase
  end

  // ---------------------------------------------------------------- counters
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_wptr <= '0;
    end else if (w_in_fire) begin
      r_wptr <= w_last_in ? '0 : r_wptr + BW'(1);
    end
  end

  // After bin N-1 is loaded the counter wraps to 0, which is also where the
  // eof handshake leaves it.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_k <= '0;
    end else if (w_eof_fire) begin
      r_k <= '0;
    end else if (w_out_load) begin
      r_k <= r_k + AW'(1);
    end
  end

  // ---------------------------------------------------------------- buffer
  assign w_wdata = '{re: in_real, im: in_imag};

  hermitian_sym_buf #(
    .DEPTH (M),
    .ABW   (BW)
  ) u_buf (
    .clk   (clk),
    .we    (w_in_fire),
    .waddr (r_wptr),
    .wdata (w_wdata),
    .raddr (w_raddr),
    .rdata (w_rdata)
  );

  // ---------------------------------------------------------------- index map
  // Lower half k -> k-1. Upper half k -> N-1-k; since N-1 is all ones this
  // is ~k, and its top bit is zero for k > N/2, so only the low bits matter.
  // Zero bins read address 0 to keep the read in range.
  assign w_zero_bin = (r_k == '0) || (r_k == c_half);
  assign w_mirror   = (r_k > c_half);
  assign w_raddr    = w_zero_bin ? '0 :
                      w_mirror   ? ~r_k[BW-1:0] :
                                   r_k[BW-1:0] - BW'(1);

  always_comb begin
    w_bin = '0;
`ifdef HERM_NEG_SAT_EN
    w_sat = 1'b0;
`endif
    if (!w_zero_bin) begin
      if (w_mirror) begin
        w_bin = conj_neg(w_rdata);
`ifdef HERM_NEG_SAT_EN
        w_sat = neg_overflows(w_rdata);
`endif
      end else begin
        w_bin = w_rdata;
      end
    end
  end

  // ---------------------------------------------------------------- output register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      out_valid <= 1'b0;
      out_real  <= '0;
      out_imag  <= '0;
      out_sof   <= 1'b0;
      out_eof   <= 1'b0;
      out_idx   <= '0;
`ifdef HERM_NEG_SAT_EN
      sat_flag  <= 1'b0;
`endif
    end else if (w_eof_fire) begin
      out_valid <= 1'b0;
      out_real  <= '0;
      out_imag  <= '0;
      out_sof   <= 1'b0;
      out_eof   <= 1'b0;
      out_idx   <= '0;
`ifdef HERM_NEG_SAT_EN
      sat_flag  <= 1'b0;
`endif
    end else if (w_out_load) begin
      out_valid <= 1'b1;
      out_real  <= w_bin.re;
      out_imag  <= w_bin.im;
      out_sof   <= (r_k == '0);
      out_eof   <= (r_k == c_last);
      out_idx   <= r_k;
`ifdef HERM_NEG_SAT_EN
      sat_flag  <= w_sat;
`endif
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_hermitian_frame_mapper.sv
`timescale 1ns/1ps
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module    : tb_hermitian_frame_mapper                                    |
// | Purpose   : Self-checking bench for hermitian_frame_mapper (N=8, W=24).  |
// |             Expected bins are queued when a frame is loaded and popped   |
// |             on every output handshake.                                   |
// | Macro     : HERM_NEG_SAT_EN - also checks sat_flag and saturation        |
// | Revision  : 1.0  initial release                                         |
// +--------------------------------------------------------------------------+
module tb_hermitian_frame_mapper;

  localparam int W  = 24;
  localparam int N  = 8;
  localparam int M  = N/2 - 1;
  localparam int AW = 3;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [W-1:0]  in_real = '0;
  logic [W-1:0]  in_imag = '0;
  logic          out_valid;
  logic          out_ready;
  logic [W-1:0]  out_real;
  logic [W-1:0]  out_imag;
  logic          out_sof;
  logic          out_eof;
  logic [AW-1:0] out_idx;
`ifdef HERM_NEG_SAT_EN
  logic          sat_flag;
`endif

  hermitian_frame_mapper #(.W(W), .N(N)) dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_real   (in_real),
    .in_imag   (in_imag),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_real  (out_real),
    .out_imag  (out_imag),
    .out_sof   (out_sof),
    .out_eof   (out_eof),
    .out_idx   (out_idx)
`ifdef HERM_NEG_SAT_EN
    ,
    .sat_flag  (sat_flag)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [W-1:0]  re;
    logic [W-1:0]  im;
    logic          sof;
    logic          eof;
    logic [AW-1:0] idx;
    logic          sat;
  } bin_t;

  bin_t         sb[$];
  int           n_vec = 0;
  int           n_err = 0;
  int           cyc = 0;
  logic [W-1:0] sym_re [M];
  logic [W-1:0] sym_im [M];
  int           rdy_mode = 0;
  int           rpat [4] = '{1, 0, 0, 1};
  int           pidx = 0;
  bit           chk_period = 0;
  int           last_sof_cyc = -1;

  always @(posedge clk) cyc++;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // Downstream ready: always high, or the 1,0,0,1 stall pattern.
  initial begin
    out_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      if (rdy_mode == 0) begin
        out_ready = 1'b1;
      end else begin
        out_ready = (rpat[pidx % 4] != 0);
        pidx++;
      end
    end
  end

  // Reference model: expected N bins for the frame in sym_re/sym_im.
  task automatic push_frame();
    for (int k = 0; k < N; k++) begin
      bin_t b;
      int   s;
      b.re = '0; b.im = '0; b.sat = 1'b0;
      b.sof = (k == 0);
      b.eof = (k == N-1);
      b.idx = AW'(k);
      if (k >= 1 && k < N/2) begin
        b.re = sym_re[k-1];
        b.im = sym_im[k-1];
      end else if (k > N/2) begin
        s = N - k - 1;
        b.re = sym_re[s];
        if (sym_im[s] == 24'h800000) begin
`ifdef HERM_NEG_SAT_EN
          b.im  = 24'h7FFFFF;
          b.sat = 1'b1;
`else
          b.im  = 24'h800000;
`endif
        end else begin
          b.im = 24'(0) - sym_im[s];
        end
      end
      sb.push_back(b);
    end
  endtask

  // Sends the first cnt symbols; a complete frame is queued in the model.
  task automatic send_syms(input int cnt, input bit hold);
    for (int i = 0; i < cnt; i++) begin
      bit acc;
      int waited;
      acc = 1'b0;
      waited = 0;
      in_valid = 1'b1;
      in_real  = sym_re[i];
      in_imag  = sym_im[i];
      while (!acc) begin
        @(negedge clk);
        acc = in_ready;
        @(posedge clk);
        #1;
        waited++;
        if (!acc && waited > 100) begin
          check("in_accept_timeout", {31'd0, in_ready}, 32'd1);
          acc = 1'b1;
        end
      end
    end
    if (cnt == M) push_frame();
    if (!hold) in_valid = 1'b0;
  endtask

  task automatic set_frame(input int r0, input int i0, input int r1, input int i1,
                           input int r2, input int i2);
    sym_re[0] = W'(r0); sym_im[0] = W'(i0);
    sym_re[1] = W'(r1); sym_im[1] = W'(i1);
    sym_re[2] = W'(r2); sym_im[2] = W'(i2);
  endtask

  task automatic wait_drain();
    int n;
    n = 0;
    while ((sb.size() != 0 || out_valid) && n < 500) begin
      @(posedge clk);
      #1;
      n++;
    end
    check("sb_drained", sb.size(), 0);
  endtask

  // Output monitor: scoreboard pops, stall stability, in_ready rules, frame period.
  bin_t         mon_e;
  logic         prev_stall = 1'b0;
  logic         eof_last = 1'b0;
  logic [W-1:0] prev_re;
  logic [W-1:0] prev_im;
  logic [AW-1:0] prev_idx;

  always @(negedge clk) begin
    if (reset) begin
      if (prev_stall) begin
        check("stall_valid", {31'd0, out_valid}, 32'd1);
        check("stall_re", out_real, prev_re);
        check("stall_im", out_imag, prev_im);
        check("stall_idx", out_idx, prev_idx);
      end
      if (eof_last) check("in_ready_after_eof", {31'd0, in_ready}, 32'd1);
      if (out_valid) check("in_ready_emit", {31'd0, in_ready}, 32'd0);
      if (out_valid && out_ready) begin
        check("sb_has_entry", {31'd0, (sb.size() != 0)}, 32'd1);
        if (sb.size() != 0) begin
          mon_e = sb.pop_front();
          check("bin_re", out_real, mon_e.re);
          check("bin_im", out_imag, mon_e.im);
          check("bin_sof", {31'd0, out_sof}, {31'd0, mon_e.sof});
          check("bin_eof", {31'd0, out_eof}, {31'd0, mon_e.eof});
          check("bin_idx", out_idx, mon_e.idx);
`ifdef HERM_NEG_SAT_EN
          check("bin_sat", {31'd0, sat_flag}, {31'd0, mon_e.sat});
`endif
        end
        if (out_sof) begin
          if (chk_period && last_sof_cyc >= 0) check("frame_period", cyc - last_sof_cyc, 11);
          last_sof_cyc = cyc;
        end
      end
      prev_stall = out_valid && !out_ready;
      prev_re    = out_real;
      prev_im    = out_imag;
      prev_idx   = out_idx;
      eof_last   = out_valid && out_ready && out_eof;
    end else begin
      prev_stall = 1'b0;
      eof_last   = 1'b0;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset state
    #12;
    check("rst_out_valid", {31'd0, out_valid}, 32'd0);
    check("rst_out_sof", {31'd0, out_sof}, 32'd0);
    check("rst_out_real", out_real, 32'd0);
    #11 reset = 1'b1;
    @(negedge clk);
    check("rst_in_ready", {31'd0, in_ready}, 32'd1);
    check("rst_out_eof", {31'd0, out_eof}, 32'd0);
    check("rst_out_idx", out_idx, 32'd0);
    @(posedge clk); #1;

    // 1: basic frame, always ready
    set_frame(1, 2, 3, 4, 5, 6);
    send_syms(M, 1'b0);
    wait_drain();

    // 2: same frame with stalls
    rdy_mode = 1;
    pidx = 0;
    send_syms(M, 1'b0);
    wait_drain();
    rdy_mode = 0;
    @(posedge clk); #1;

    // 3: in_valid held through EMIT, carrying the next frame's first symbol
    set_frame(21, 22, 23, 24, 25, 26);
    send_syms(M, 1'b1);
    set_frame(13, 14, 15, 16, 17, 18);
    in_real = sym_re[0];
    in_imag = sym_im[0];
    repeat (4) @(posedge clk);
    #1;
    send_syms(M, 1'b0);
    wait_drain();

    // 4: reset mid-frame discards partial contents
    set_frame(31, 32, 33, 34, 35, 36);
    send_syms(2, 1'b0);
    #3 reset = 1'b0;
    #2;
    check("midrst_out_valid", {31'd0, out_valid}, 32'd0);
    repeat (2) @(posedge clk);
    #3 reset = 1'b1;
    @(negedge clk);
    check("midrst_in_ready", {31'd0, in_ready}, 32'd1);
    @(posedge clk); #1;
    set_frame(7, 8, 9, 10, 11, 12);
    send_syms(M, 1'b0);
    wait_drain();

    // 5: most-negative imaginary part in the mirror
    set_frame(100, -8388608, -5, 7, 0, -1);
    send_syms(M, 1'b0);
    wait_drain();

    // 6: back-to-back frames, both sides always ready
    chk_period = 1'b1;
    last_sof_cyc = -1;
    set_frame(41, -42, 43, -44, 45, -46);
    send_syms(M, 1'b1);
    set_frame(-51, 52, -53, 54, -55, 56);
    send_syms(M, 1'b1);
    set_frame(61, 62, 63, 64, 65, 66);
    send_syms(M, 1'b0);
    wait_drain();
    chk_period = 1'b0;

    repeat (2) @(posedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire
